reversing_bits: RTL and testbench
=================================

# reversing_bits

Registered datapath block that reverses the order of bits in a `DATA_WIDTH`-bit word. It also supports pass-through, byte-swap and bit-reverse-within-byte modes, selected per word. It sits inline on a streaming data path: one input word is accepted per cycle, and the transformed word is presented one cycle later with a matching valid flag.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: word width. Must be ≥ 8 and a multiple of 8; any other value is an elaboration error.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `din`, input, `DATA_WIDTH`: input word.
- `din_valid`, input, 1: `din` and `mode` are valid this cycle.
- `mode`, input, 2: transform select, sampled with `din`.
- `dout`, output, `DATA_WIDTH`: transformed word (registered).
- `dout_valid`, output, 1: `dout` holds a new result this cycle.
- `dout_par`, output, 1: present only with `REVERSING_BITS_PARITY_EN`.

## Operation
- `mode` encoding:
  - 0 PASS: `dout = din`.
  - 1 BITREV: `dout[i] = din[DATA_WIDTH-1-i]` for all i.
  - 2 BYTESWAP: byte k of `dout` = byte (N-1-k) of `din`, where N = `DATA_WIDTH`/8.
  - 3 BITREV_IN_BYTE: each byte is bit-reversed in place; byte order is unchanged.
- When `din_valid` = 1: the transform of `din` is loaded into `dout`, and `dout_valid` is set to 1.
- When `din_valid` = 0: `dout` holds its previous value, and `dout_valid` is set to 0.
- No backpressure; the block always accepts input.
- Transforms are pure bit permutations. No arithmetic; the output width equals the input width.
- Identities: BITREV equals BYTESWAP composed with BITREV_IN_BYTE. Applying any mode twice yields the original word.

## Timing
- Latency: exactly 1 cycle from a `din_valid` cycle to the corresponding `dout_valid` cycle.
- Throughput: 1 word per cycle. Back-to-back valid inputs produce back-to-back valid outputs.
- Reset values: `dout` = 0, `dout_valid` = 0, `dout_par` = 0.
- Reset has priority over `din_valid` in the same cycle: that input is dropped.
- Reset mid-stream: the output asserted on the next edge is the reset value. The first valid input after `reset` deasserts produces output 1 cycle later as normal.
- A `mode` change between consecutive words takes effect on the word it accompanies. There is no dead cycle.

## Configuration
- `REVERSING_BITS_PARITY_EN` defined:
  - adds output `dout_par`, registered alongside `dout`;
  - `dout_par` = XOR-reduction (even-parity bit) of the value loaded into `dout`;
  - follows the same load/hold and reset rules as `dout`.
- Not defined: the `dout_par` port and its logic are absent. All other behaviour is identical.

## Structure
- Package `reversing_bits_pkg` holds:
  - the `mode` typedef enum (`REV_PASS`, `REV_BITREV`, `REV_BYTESWAP`, `REV_BITREV_IN_BYTE`);
  - the mode width constant.
- Sub-module `reversing_bits_net`: purely combinational permutation network. It is parameterised by `DATA_WIDTH`, takes `din` and `mode`, and produces the next `dout`.
- The top level contains only the output registers, the valid register, and the optional parity logic.

## Test plan
- Reset → `dout` = 0, `dout_valid` = 0. Then `din` = 32'h0000000B with BITREV → next cycle `dout` = 32'hD0000000, `dout_valid` = 1.
- `din` = 32'h12345678 BYTESWAP, then BITREV_IN_BYTE on 32'h0000000B, then PASS on 32'hCAFEF00D (back-to-back) → consecutive outputs 32'h78563412, 32'h000000D0, 32'hCAFEF00D, with `dout_valid` high for 3 cycles.
- Valid word 32'hFFFF0000 BITREV, then 2 cycles with `din_valid` = 0 → `dout` = 32'h0000FFFF, held; `dout_valid` = 1 then 0 for 2 cycles.
- `reset` asserted together with valid 32'hA5A5A5A5 → the word is dropped: next `dout` = 0, `dout_valid` = 0.
- 10 random words in random modes, checked against a model, plus a double-application check → every output equals the model; double application returns the original.
- With `REVERSING_BITS_PARITY_EN`: 32'h0000000B BITREV → `dout_par` = 1. Then 32'h00000003 PASS → `dout_par` = 0.

Source files
------------

// File: rtl/reversing_bits_pkg.sv
// Shared types for the reversing_bits block: transform mode encoding and its width.
package reversing_bits_pkg;

  localparam int MODE_WIDTH = 2;

  typedef enum logic [MODE_WIDTH-1:0] {
    REV_PASS           = 2'd0,
    REV_BITREV         = 2'd1,
    REV_BYTESWAP       = 2'd2,
    REV_BITREV_IN_BYTE = 2'd3
  } rev_mode_t;

endpackage

// File: rtl/reversing_bits_net.sv
// Combinational permutation network: pass, full bit reverse, byte swap, or
// bit reverse within each byte, selected by mode.
module reversing_bits_net
  import reversing_bits_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [MODE_WIDTH-1:0] mode,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] bit_rev;
  logic [DATA_WIDTH-1:0] byte_swap;
  logic [DATA_WIDTH-1:0] rev_in_byte;

  always_comb begin
    bit_rev     = '0;
    byte_swap   = '0;
    rev_in_byte = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      bit_rev[i] = din[DATA_WIDTH-1-i];
    end
    for (int k = 0; k < NUM_BYTES; k++) begin
      byte_swap[8*k +: 8] = din[8*(NUM_BYTES-1-k) +: 8];
      for (int b = 0; b < 8; b++) begin
        rev_in_byte[8*k+b] = din[8*k+7-b];
      end
    end
  end

  always_comb begin
    dout = din;
    case (rev_mode_t'(mode))
      REV_PASS:           dout = din;
      REV_BITREV:         dout = bit_rev;
      REV_BYTESWAP:       dout = byte_swap;
      REV_BITREV_IN_BYTE: dout = rev_in_byte;
      default:            dout = din;
    endcase
  end

endmodule

// File: rtl/reversing_bits.sv
// Registered bit/byte reversal stage with one-cycle latency.
// Optional even-parity output dout_par is enabled by defining REVERSING_BITS_PARITY_EN.
module reversing_bits
  import reversing_bits_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic [MODE_WIDTH-1:0] mode,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid
`ifdef REVERSING_BITS_PARITY_EN
  ,
  output logic                  dout_par
`endif
);

  if ((DATA_WIDTH < 8) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_width
    $error("reversing_bits: DATA_WIDTH must be >= 8 and a multiple of 8");
  end

  logic [DATA_WIDTH-1:0] next_dout;

  reversing_bits_net #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_net (
    .din (din),
    .mode(mode),
    .dout(next_dout)
  );

  // Reset wins over a same-cycle valid word; idle cycles hold the last result.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= din_valid;
      if (din_valid) begin
        dout <= next_dout;
      end
    end
  end

`ifdef REVERSING_BITS_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_par <= 1'b0;
    end else if (din_valid) begin
      dout_par <= ^next_dout;
    end
  end
`endif

endmodule

// File: tb/tb_reversing_bits.sv
// Self-checking bench for reversing_bits: directed vector table, random words
// against a reference model, and double-application round trips.
module tb_reversing_bits;

  logic        clk;
  logic        reset;
  logic [31:0] din;
  logic        din_valid;
  logic [1:0]  mode;
  logic [31:0] dout;
  logic        dout_valid;
`ifdef REVERSING_BITS_PARITY_EN
  logic        dout_par;
`endif

  int vec_count  = 0;
  int miscompare = 0;

  reversing_bits #(
    .DATA_WIDTH(32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .mode      (mode),
    .dout      (dout),
    .dout_valid(dout_valid)
`ifdef REVERSING_BITS_PARITY_EN
    ,
    .dout_par  (dout_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [1:0]  md;
    logic [31:0] data;
    logic [31:0] exp_dout;
    logic        exp_valid;
    logic        exp_par;
  } vec_t;

  vec_t vecs[14];

  // Reference model written independently of the RTL structure.
  function automatic logic [31:0] ref_bitrev(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[31-i] = w[i];
    return r;
  endfunction

  function automatic logic [31:0] ref_byteswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [31:0] ref_model(input logic [31:0] w, input logic [1:0] m);
    case (m)
      2'd0:    return w;
      2'd1:    return ref_bitrev(w);
      2'd2:    return ref_byteswap(w);
      default: return ref_byteswap(ref_bitrev(w));
    endcase
  endfunction

  task automatic applyStimulus(input logic rst, input logic valid,
                               input logic [1:0] md, input logic [31:0] data);
    @(negedge clk);
    reset     = rst;
    din_valid = valid;
    mode      = md;
    din       = data;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] exp_dout,
                             input logic exp_valid, input logic exp_par);
    vec_count++;
    if (dout !== exp_dout || dout_valid !== exp_valid) begin
      miscompare++;
      $display("[TB] FAIL %s: dout=%h valid=%b, expected dout=%h valid=%b",
               name, dout, dout_valid, exp_dout, exp_valid);
    end
`ifdef REVERSING_BITS_PARITY_EN
    vec_count++;
    if (dout_par !== exp_par) begin
      miscompare++;
      $display("[TB] FAIL %s parity: dout_par=%b, expected %b", name, dout_par, exp_par);
    end
`else
    if (exp_par === 1'bx) $display("[TB] note: unknown parity expectation in %s", name);
`endif
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] once;
    logic [1:0]  m;

    reset     = 1'b1;
    din_valid = 1'b0;
    mode      = 2'd0;
    din       = 32'h0;

    //           rst   valid md    data          exp_dout      exp_v exp_par
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 2'd1, 32'h0000000B, 32'hD0000000, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 2'd2, 32'h12345678, 32'h78563412, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 2'd3, 32'h0000000B, 32'h000000D0, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 2'd0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 2'd1, 32'hFFFF0000, 32'h0000FFFF, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 2'd1, 32'h12345678, 32'h0000FFFF, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 2'd2, 32'hDEADBEEF, 32'h0000FFFF, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 2'd1, 32'hA5A5A5A5, 32'h00000000, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 2'd1, 32'hA5A5A5A5, 32'h00000000, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 2'd2, 32'h000000FF, 32'hFF000000, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 2'd3, 32'h80000001, 32'h01000080, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 2'd1, 32'h12345678, 32'h1E6A2C48, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 2'd0, 32'h00000003, 32'h00000003, 1'b1, 1'b0};

    repeat (2) @(posedge clk);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].md, vecs[i].data);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_valid, vecs[i].exp_par);
    end

    // Back-to-back random words in random modes.
    for (int i = 0; i < 10; i++) begin
      w    = $urandom;
      m    = 2'($urandom_range(0, 3));
      once = ref_model(w, m);
      applyStimulus(1'b0, 1'b1, m, w);
      checkOutput($sformatf("rand%0d_m%0d", i, m), once, 1'b1, ^once);
    end

    // Each mode applied twice must restore the original word.
    for (int k = 0; k < 4; k++) begin
      w    = $urandom;
      m    = 2'(k);
      once = ref_model(w, m);
      applyStimulus(1'b0, 1'b1, m, w);
      checkOutput($sformatf("twice%0d_first", k), once, 1'b1, ^once);
      applyStimulus(1'b0, 1'b1, m, once);
      checkOutput($sformatf("twice%0d_second", k), w, 1'b1, ^w);
    end

    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
    checkOutput("final_idle", w, 1'b0, ^w);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare);
    $finish;
  end

endmodule
